// File: rtl/apb_event_irq_pkg.sv
// Shared definitions for the APB event/interrupt controller: register
// offsets, sleep FSM state encoding and STATUS field positions.
package apb_event_irq_pkg;

  localparam logic [31:0] OFF_IRQ_MASK    = 32'h00;
  localparam logic [31:0] OFF_IRQ_PENDING = 32'h04;
  localparam logic [31:0] OFF_IRQ_SET     = 32'h08;
  localparam logic [31:0] OFF_EVT_MASK    = 32'h0C;
  localparam logic [31:0] OFF_EVT_PENDING = 32'h10;
  localparam logic [31:0] OFF_LEVEL_MODE  = 32'h14;
  localparam logic [31:0] OFF_SLEEP_CTRL  = 32'h18;
  localparam logic [31:0] OFF_STATUS      = 32'h1C;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SLEEP_REQ = 2'd1,
    ST_SLEEP     = 2'd2,
    ST_WAKE      = 2'd3
  } state_t;

  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_ID_LSB    = 8;
  localparam int STATUS_IRQ_BIT   = 31;

  // Interrupt ID width; a single line still needs a one-bit ID.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/event_line_capture.sv
// Per-line pending capture: rising-edge or level detect, software set,
// software W1C and hardware (ack) clear. A new capture beats any clear.
module event_line_capture #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] line,
  input  logic [WIDTH-1:0] level_mode,
  input  logic [WIDTH-1:0] sw_set,
  input  logic [WIDTH-1:0] sw_clr,
  input  logic [WIDTH-1:0] hw_clr,
  output logic [WIDTH-1:0] pending
);

  logic [WIDTH-1:0] line_q;
  logic [WIDTH-1:0] hit;

  // Level lines capture while high; edge lines only on a 0->1 transition.
  always_comb begin
    hit = (level_mode & line) | (~level_mode & line & ~line_q);
  end

  // Edge history and pending bits; set terms are OR'd after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q  <= '0;
      pending <= '0;
    end else begin
      line_q  <= line;
      pending <= (pending & ~(sw_clr | hw_clr)) | hit | sw_set;
    end
  end

endmodule

// File: rtl/apb_event_irq_ctrl.sv
// APB event/interrupt controller: masked, prioritised interrupt request
// with ack handshake, plus a sleep FSM gating core fetch and clock.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// RUN       | core running, fetch and clock enabled
// SLEEP_REQ | fetch stopped, waiting for core to drain outstanding work
// SLEEP     | fetch stopped and core clock gated
// WAKE      | clock restored, fetch re-enabled on the following cycle
module apb_event_irq_ctrl
  import apb_event_irq_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_LINES      = 32,
  parameter int ID_WIDTH       = id_width(NUM_LINES)
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_LINES-1:0]      irq_i,
  input  logic [NUM_LINES-1:0]      event_i,
  input  logic                      irq_ack_i,
  input  logic [ID_WIDTH-1:0]       irq_ack_id_i,
  input  logic                      core_busy_i,
  output logic                      irq_o,
  output logic [ID_WIDTH-1:0]       irq_id_o,
  output logic                      fetch_enable_o,
  output logic                      clk_gate_en_o
);

  logic [31:0]          addr;
  logic                 addr_valid;
  logic                 wr;
  logic                 rd;
  logic [NUM_LINES-1:0] wdata;
  logic [NUM_LINES-1:0] irq_mask;
  logic [NUM_LINES-1:0] evt_mask;
  logic [NUM_LINES-1:0] level_mode;
  logic [NUM_LINES-1:0] irq_pend;
  logic [NUM_LINES-1:0] evt_pend;
  logic [NUM_LINES-1:0] irq_set;
  logic [NUM_LINES-1:0] irq_clr;
  logic [NUM_LINES-1:0] evt_clr;
  logic [NUM_LINES-1:0] ack_clr;
  logic [NUM_LINES-1:0] irq_active;
  logic                 hit;
  logic [ID_WIDTH-1:0]  hit_id;
  logic                 wake;
  logic                 sleep_req;
  logic [31:0]          status;
  state_t               state;
  state_t               state_next;

  assign addr   = 32'(PADDR);
  assign wr     = PSEL & PENABLE & PWRITE & addr_valid;
  assign rd     = PSEL & PENABLE & ~PWRITE & addr_valid;
  assign wdata  = PWDATA[NUM_LINES-1:0];
  assign PREADY = 1'b1;

  // Address decode: only the eight word offsets of the map respond.
  always_comb begin
    case (addr)
      OFF_IRQ_MASK, OFF_IRQ_PENDING, OFF_IRQ_SET, OFF_EVT_MASK,
      OFF_EVT_PENDING, OFF_LEVEL_MODE, OFF_SLEEP_CTRL, OFF_STATUS:
        addr_valid = 1'b1;
      default: addr_valid = 1'b0;
    endcase
    PSLVERR = PSEL & PENABLE & ~addr_valid;
  end

  // Write strobes for the pending registers and the sleep request.
  always_comb begin
    irq_set   = (wr && addr == OFF_IRQ_SET)     ? wdata : '0;
    irq_clr   = (wr && addr == OFF_IRQ_PENDING) ? wdata : '0;
    evt_clr   = (wr && addr == OFF_EVT_PENDING) ? wdata : '0;
    sleep_req = wr && addr == OFF_SLEEP_CTRL && PWDATA[0];
  end

  // Configuration registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_mask   <= '0;
      evt_mask   <= '0;
      level_mode <= '0;
    end else if (wr) begin
      case (addr)
        OFF_IRQ_MASK:   irq_mask   <= wdata;
        OFF_EVT_MASK:   evt_mask   <= wdata;
        OFF_LEVEL_MODE: level_mode <= wdata;
        default: ;
      endcase
    end
  end

  // Ack decode; IDs at or above NUM_LINES match no line and are dropped.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_LINES; i++)
      ack_clr[i] = irq_ack_i && (irq_ack_id_i == i[ID_WIDTH-1:0]);
  end

  event_line_capture #(.WIDTH(NUM_LINES)) u_irq_cap (
    .clk        (HCLK),
    .rst        (HRESET),
    .line       (irq_i),
    .level_mode (level_mode),
    .sw_set     (irq_set),
    .sw_clr     (irq_clr),
    .hw_clr     (ack_clr),
    .pending    (irq_pend)
  );

  event_line_capture #(.WIDTH(NUM_LINES)) u_evt_cap (
    .clk        (HCLK),
    .rst        (HRESET),
    .line       (event_i),
    .level_mode (level_mode),
    .sw_set     ('0),
    .sw_clr     (evt_clr),
    .hw_clr     ('0),
    .pending    (evt_pend)
  );

  // Lowest-index active line wins: scan downward so the last hit sticks.
  always_comb begin
    irq_active = irq_pend & irq_mask;
    hit        = 1'b0;
    hit_id     = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (irq_active[i]) begin
        hit    = 1'b1;
        hit_id = i[ID_WIDTH-1:0];
      end
    end
    wake = |(evt_pend & evt_mask) | (|irq_active);
  end

  // Registered interrupt request; the ID holds while no line is active.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_o    <= 1'b0;
      irq_id_o <= '0;
    end else begin
      irq_o <= hit;
      if (hit) irq_id_o <= hit_id;
    end
  end

  // Sleep FSM state register.
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_RUN;
    else        state <= state_next;
  end

  // Sleep FSM next state; a request made while already woken is dropped.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:       if (sleep_req && !wake) state_next = ST_SLEEP_REQ;
      ST_SLEEP_REQ: if (wake) state_next = ST_WAKE;
                    else if (!core_busy_i) state_next = ST_SLEEP;
      ST_SLEEP:     if (wake) state_next = ST_WAKE;
      ST_WAKE:      state_next = ST_RUN;
      default:      state_next = ST_RUN;
    endcase
  end

  // Sleep FSM outputs.
  always_comb begin
    fetch_enable_o = (state == ST_RUN);
    clk_gate_en_o  = (state != ST_SLEEP);
  end

  // Read mux; write-only registers and idle bus read as zero.
  always_comb begin
    status = '0;
    status[STATUS_STATE_LSB +: 2]        = state;
    status[STATUS_ID_LSB +: ID_WIDTH]    = irq_id_o;
    status[STATUS_IRQ_BIT]               = irq_o;
    PRDATA = '0;
    if (rd) begin
      case (addr)
        OFF_IRQ_MASK:    PRDATA = 32'(irq_mask);
        OFF_IRQ_PENDING: PRDATA = 32'(irq_pend);
        OFF_EVT_MASK:    PRDATA = 32'(evt_mask);
        OFF_EVT_PENDING: PRDATA = 32'(evt_pend);
        OFF_LEVEL_MODE:  PRDATA = 32'(level_mode);
        OFF_STATUS:      PRDATA = status;
        default:         PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_event_irq_ctrl.sv
// Directed bench for apb_event_irq_ctrl: register access, priority/ack,
// level capture, sleep/wake sequencing and reset out of sleep.
module tb_apb_event_irq_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] irq_i;
  logic [31:0] event_i;
  logic        irq_ack_i;
  logic [4:0]  irq_ack_id_i;
  logic        core_busy_i;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic        fetch_enable_o;
  logic        clk_gate_en_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rdata;
  logic        rerr;

  apb_event_irq_ctrl #(.APB_ADDR_WIDTH(12), .NUM_LINES(32)) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .PADDR          (PADDR),
    .PWDATA         (PWDATA),
    .PWRITE         (PWRITE),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .PRDATA         (PRDATA),
    .PREADY         (PREADY),
    .PSLVERR        (PSLVERR),
    .irq_i          (irq_i),
    .event_i        (event_i),
    .irq_ack_i      (irq_ack_i),
    .irq_ack_id_i   (irq_ack_id_i),
    .core_busy_i    (core_busy_i),
    .irq_o          (irq_o),
    .irq_id_o       (irq_id_o),
    .fetch_enable_o (fetch_enable_o),
    .clk_gate_en_o  (clk_gate_en_o)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; write commits on the second following edge.
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge HCLK); #1 PENABLE = 1'b1;
    @(posedge HCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(posedge HCLK); #1 PENABLE = 1'b1;
    @(negedge HCLK); d = PRDATA; e = PSLVERR;
    @(posedge HCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic ack(input logic [4:0] id);
    irq_ack_i = 1'b1; irq_ack_id_i = id;
    @(posedge HCLK); #1 irq_ack_i = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    irq_i = '0; event_i = '0; irq_ack_i = 1'b0; irq_ack_id_i = '0; core_busy_i = 1'b0;
    @(posedge HCLK); @(posedge HCLK);
    @(negedge HCLK);
    check("rst_irq_o", 32'(irq_o), 32'd0);
    check("rst_fetch", 32'(fetch_enable_o), 32'd1);
    check("rst_clkgate", 32'(clk_gate_en_o), 32'd1);
    check("rst_pready", 32'(PREADY), 32'd1);
    check("rst_prdata_idle", PRDATA, 32'd0);
    @(posedge HCLK); #1 HRESET = 1'b0;

    // Register reset values
    apb_read(12'h000, rdata, rerr); check("rst_irq_mask", rdata, 32'h0);
    check("rst_irq_mask_err", 32'(rerr), 32'd0);
    apb_read(12'h004, rdata, rerr); check("rst_irq_pend", rdata, 32'h0);
    apb_read(12'h00C, rdata, rerr); check("rst_evt_mask", rdata, 32'h0);
    apb_read(12'h010, rdata, rerr); check("rst_evt_pend", rdata, 32'h0);
    apb_read(12'h014, rdata, rerr); check("rst_level", rdata, 32'h0);
    apb_read(12'h01C, rdata, rerr); check("rst_status", rdata, 32'h0);

    // Unmapped offset
    apb_read(12'h020, rdata, rerr);
    check("unmapped_err", 32'(rerr), 32'd1);
    check("unmapped_data", rdata, 32'h0);
    apb_write(12'h020, 32'hFFFF_FFFF);
    apb_read(12'h000, rdata, rerr); check("unmapped_no_write", rdata, 32'h0);
    apb_read(12'h014, rdata, rerr); check("unmapped_no_write_lvl", rdata, 32'h0);

    // Priority and ack
    apb_write(12'h000, 32'h0000_0014);
    irq_i = 32'h14;
    @(posedge HCLK); #1 irq_i = '0;
    @(negedge HCLK); check("irq_latency_1cyc", 32'(irq_o), 32'd0);
    @(negedge HCLK);
    check("irq_o_2cyc", 32'(irq_o), 32'd1);
    check("irq_id_2", 32'(irq_id_o), 32'd2);
    @(posedge HCLK); #1;
    apb_read(12'h004, rdata, rerr); check("irq_pend_14", rdata, 32'h14);
    ack(5'd2);
    @(posedge HCLK); @(negedge HCLK);
    check("ack2_irq_o", 32'(irq_o), 32'd1);
    check("ack2_id_4", 32'(irq_id_o), 32'd4);
    @(posedge HCLK); #1;
    ack(5'd4);
    @(posedge HCLK); @(negedge HCLK);
    check("ack4_irq_o", 32'(irq_o), 32'd0);
    check("ack4_id_hold", 32'(irq_id_o), 32'd4);
    @(posedge HCLK); #1;

    // Level mode: set wins over W1C while the line is high
    apb_write(12'h014, 32'h8);
    irq_i = 32'h8;
    @(posedge HCLK); #1;
    apb_write(12'h004, 32'h8);
    apb_read(12'h004, rdata, rerr); check("level_w1c_held", rdata, 32'h8);
    irq_i = '0;
    @(posedge HCLK); #1;
    apb_write(12'h004, 32'h8);
    apb_read(12'h004, rdata, rerr); check("level_w1c_released", rdata, 32'h0);

    // Edge and ack of the same line in one cycle
    irq_i = 32'h2; irq_ack_i = 1'b1; irq_ack_id_i = 5'd1;
    @(posedge HCLK); #1 irq_i = '0; irq_ack_i = 1'b0;
    apb_read(12'h004, rdata, rerr); check("set_beats_ack", rdata, 32'h2);
    apb_write(12'h004, 32'h2);
    apb_read(12'h004, rdata, rerr); check("w1c_bit1", rdata, 32'h0);

    // Software set
    apb_write(12'h008, 32'h10);
    apb_read(12'h008, rdata, rerr); check("irq_set_reads0", rdata, 32'h0);
    apb_read(12'h01C, rdata, rerr); check("status_irq4", rdata, 32'h8000_0400);
    apb_write(12'h004, 32'h10);
    apb_read(12'h004, rdata, rerr); check("irq_set_cleared", rdata, 32'h0);

    // Sleep request while core busy, then sleep, then event wake
    apb_write(12'h00C, 32'h1);
    core_busy_i = 1'b1;
    apb_write(12'h018, 32'h1);
    @(negedge HCLK);
    check("sreq_fetch", 32'(fetch_enable_o), 32'd0);
    check("sreq_clkgate", 32'(clk_gate_en_o), 32'd1);
    @(posedge HCLK); #1;
    apb_read(12'h01C, rdata, rerr); check("sreq_status", rdata, 32'h0000_0401);
    core_busy_i = 1'b0;
    @(posedge HCLK); @(negedge HCLK);
    check("sleep_clkgate", 32'(clk_gate_en_o), 32'd0);
    check("sleep_fetch", 32'(fetch_enable_o), 32'd0);
    @(posedge HCLK); #1;
    apb_read(12'h01C, rdata, rerr); check("sleep_status", rdata, 32'h0000_0402);
    event_i = 32'h1;
    @(posedge HCLK); #1 event_i = '0;
    @(negedge HCLK); check("wake_lat_clkgate", 32'(clk_gate_en_o), 32'd0);
    @(negedge HCLK);
    check("wake_clkgate", 32'(clk_gate_en_o), 32'd1);
    check("wake_fetch", 32'(fetch_enable_o), 32'd0);
    @(negedge HCLK);
    check("run_fetch", 32'(fetch_enable_o), 32'd1);
    @(posedge HCLK); #1;
    apb_read(12'h010, rdata, rerr); check("evt_pend_sticky", rdata, 32'h1);

    // Request dropped when a wake condition already holds
    apb_write(12'h018, 32'h1);
    @(negedge HCLK); check("drop_req_fetch", 32'(fetch_enable_o), 32'd1);
    @(posedge HCLK); #1;
    apb_read(12'h01C, rdata, rerr); check("drop_req_status", rdata, 32'h0000_0400);

    // Reset while asleep
    apb_write(12'h010, 32'h1);
    apb_write(12'h018, 32'h1);
    @(posedge HCLK); @(negedge HCLK);
    check("pre_rst_sleep", 32'(clk_gate_en_o), 32'd0);
    @(posedge HCLK); #1 HRESET = 1'b1;
    @(posedge HCLK); @(negedge HCLK);
    check("rst_sleep_fetch", 32'(fetch_enable_o), 32'd1);
    check("rst_sleep_clkgate", 32'(clk_gate_en_o), 32'd1);
    @(posedge HCLK); #1 HRESET = 1'b0;
    apb_read(12'h000, rdata, rerr); check("rst_sleep_irq_mask", rdata, 32'h0);
    apb_read(12'h00C, rdata, rerr); check("rst_sleep_evt_mask", rdata, 32'h0);
    apb_read(12'h01C, rdata, rerr); check("rst_sleep_status", rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
